mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the execute `result` as either a load/store address or a pass-through value.
- Runs the data-memory request/acknowledge handshake and performs byte-lane alignment and load sign/zero extension.
- Registers a single write-back bundle for the register file and holds the upstream pipeline stalled while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_load_align.sv | 26 ++
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and bundle widths.
package mem_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int F3_W  = 3;

    localparam logic [F3_W-1:0] LS_B  = 3'b000;
    localparam logic [F3_W-1:0] LS_H  = 3'b001;
    localparam logic [F3_W-1:0] LS_W  = 3'b010;
    localparam logic [F3_W-1:0] LS_BU = 3'b100;
    localparam logic [F3_W-1:0] LS_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half lane out of a read word and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [F3_W-1:0] funct3,
    output logic [XLEN-1:0] data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = rdata[8*addr_lo +: 8];
        half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LS_B:    data = {{24{byte_s[7]}}, byte_s};
            LS_BU:   data = {24'd0, byte_s};
            LS_H:    data = {{16{half_s[15]}}, half_s};
            LS_HU:   data = {16'd0, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs the dmem req/ack handshake, aligns loads and stores,
// and registers one write-back bundle per accepted instruction.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [F3_W-1:0]  funct3,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [XLEN-1:0]  store_data,
    input  logic [REG_W-1:0] rd_in,
    input  logic             reg_write_in,
    output logic             stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_ack,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             wb_valid,
    output logic [XLEN-1:0]  wb_data,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_reg_write,
    output logic             exc_misaligned,
    output logic             exc_bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        addr_lo_q;
    logic [F3_W-1:0]   funct3_q;
    logic [REG_W-1:0]  rd_q;
    logic              reg_write_q;

    logic              mem_op, acc_ok, accept, start, timed_out;
    logic [XLEN-1:0]   wdata_d, load_val;
    logic [3:0]        wstrb_d;

    assign mem_op    = mem_read | mem_write;
    assign accept    = (state_q == ST_IDLE) && in_valid;
    assign start     = accept && mem_op && acc_ok;
    assign timed_out = (state_q == ST_WAIT) && !dmem_ack && (cnt_q == CNT_LAST);
    assign stall     = (state_q == ST_WAIT) || start;

    always_comb begin
        acc_ok = 1'b0;
        case (funct3)
            LS_B, LS_BU: acc_ok = 1'b1;
            LS_H, LS_HU: acc_ok = ~ex_result[0];
            LS_W:        acc_ok = (ex_result[1:0] == 2'b00);
            default:     acc_ok = 1'b0;
        endcase
    end

    // Store lanes: replicate narrow data so the strobes alone pick the bytes.
    always_comb begin
        wdata_d = store_data;
        wstrb_d = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_d = {4{store_data[7:0]}};
                wstrb_d = 4'b0001 << ex_result[1:0];
            end
            2'b01: begin
                wdata_d = {2{store_data[15:0]}};
                wstrb_d = 4'b0011 << ex_result[1:0];
            end
            default: ;
        endcase
        if (!mem_write) wstrb_d = 4'b0000;
    end

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data    (load_val)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_WAIT;
            ST_WAIT: if (dmem_ack || timed_out) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= '0;
            addr_lo_q      <= '0;
            funct3_q       <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_rd          <= '0;
            wb_reg_write   <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus_error  <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_bus_error  <= 1'b0;
            if (start) begin
                dmem_req    <= 1'b1;
                dmem_we     <= mem_write;
                dmem_addr   <= {ex_result[XLEN-1:2], 2'b00};
                dmem_wdata  <= wdata_d;
                dmem_wstrb  <= wstrb_d;
                addr_lo_q   <= ex_result[1:0];
                funct3_q    <= funct3;
                rd_q        <= rd_in;
                reg_write_q <= reg_write_in & mem_read;
                cnt_q       <= '0;
            end else if (accept) begin
                // Pass-through result, or a rejected access reported as misaligned.
                wb_valid       <= 1'b1;
                wb_data        <= ex_result;
                wb_rd          <= rd_in;
                wb_reg_write   <= reg_write_in & ~mem_op;
                exc_misaligned <= mem_op;
            end else if (state_q == ST_WAIT) begin
                if (dmem_ack) begin
                    dmem_req     <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= rd_q;
                    wb_reg_write <= reg_write_q;
                    if (!dmem_we) wb_data <= load_val;
                end else if (timed_out) begin
                    dmem_req      <= 1'b0;
                    wb_valid      <= 1'b1;
                    wb_rd         <= rd_q;
                    wb_reg_write  <= 1'b0;
                    exc_bus_error <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write, reg_write_in;
    logic [2:0]  funct3;
    logic [31:0] ex_result, store_data, dmem_rdata;
    logic [4:0]  rd_in;
    logic        dmem_ack;
    logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_write, exc_misaligned, exc_bus_error;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .ex_result(ex_result), .store_data(store_data), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .exc_misaligned(exc_misaligned),
        .exc_bus_error(exc_bus_error)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        berr;
        logic        chk_payload;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          lat, stall_cyc, req_cyc;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_we, req_changed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference for load extension.
    function automatic logic [31:0] ext_model(input logic [31:0] rdata, input logic [1:0] a,
                                              input logic [2:0] f3);
        logic [31:0] sh;
        sh = rdata >> (8 * a);
        case (f3)
            3'b000:  return (sh[7]  ? 32'hFFFF_FF00 : 32'h0) | (sh & 32'hFF);
            3'b100:  return sh & 32'hFF;
            3'b001:  return (sh[15] ? 32'hFFFF_0000 : 32'h0) | (sh & 32'hFFFF);
            3'b101:  return sh & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic [4:0] r, input logic rw,
                                input logic mis, input logic berr, input logic cp);
        exp_t e;
        e.data = d; e.rd = r; e.rw = rw; e.mis = mis; e.berr = berr; e.chk_payload = cp;
        return e;
    endfunction

    // Drives one bundle, supplies ack on the ack_after-th request cycle (0 = never),
    // and checks the resulting write-back against the scoreboard head.
    task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input int ack_after, input logic [31:0] rdata);
        exp_t e;
        in_valid = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3;
        ex_result = addr; store_data = sd; rd_in = rd; reg_write_in = rw;
        lat = 0; stall_cyc = 0; req_cyc = 0; req_changed = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0; req_we = 1'b0;
        while (lat < 50) begin
            #1;
            if (stall) stall_cyc++;
            if (dmem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    req_addr = dmem_addr; req_we = dmem_we;
                    req_wdata = dmem_wdata; req_wstrb = dmem_wstrb;
                end else if (dmem_addr !== req_addr || dmem_we !== req_we ||
                             dmem_wdata !== req_wdata || dmem_wstrb !== req_wstrb) begin
                    req_changed = 1'b1;
                end
                if (req_cyc == ack_after) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0; in_valid = 1'b0; lat++;
            if (wb_valid) break;
        end
        chk("wb_arrived", 32'(wb_valid), 32'd1);
        if (wb_valid) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_payload) begin
                    chk("wb_data", wb_data, e.data);
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                end
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("exc_misaligned", 32'(exc_misaligned), 32'(e.mis));
                chk("exc_bus_error", 32'(exc_bus_error), 32'(e.berr));
            end
        end
        chk("req_stable", 32'(req_changed), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        ex_result = '0; store_data = '0; rd_in = '0; reg_write_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("rst_exc", 32'({exc_misaligned, exc_bus_error}), 32'd0);
        rst = 1'b0;

        // ALU pass-through
        sb.push_back(mk(32'h1234_5678, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        issue(1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 0, 32'h0);
        chk("alu_lat", 32'(lat), 32'd1);
        chk("alu_stall", 32'(stall_cyc), 32'd0);
        chk("alu_req", 32'(req_cyc), 32'd0);

        // Ack while idle is ignored; wb_data holds
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1; dmem_ack = 1'b0;
        chk("idle_ack_wb", 32'(wb_valid), 32'd0);
        chk("idle_ack_req", 32'(dmem_req), 32'd0);
        chk("wb_data_hold", wb_data, 32'h1234_5678);

        // LB sign extension, ack in the final timeout cycle (ack wins)
        sb.push_back(mk(ext_model(32'h80FF_1122, 2'd3, 3'b000), 5'd7, 1'b1, 1'b0, 1'b0, 1'b1));
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 4, 32'h80FF_1122);
        chk("lb_addr", req_addr, 32'h0000_0100);
        chk("lb_we", 32'(req_we), 32'd0);
        chk("lb_wstrb", 32'(req_wstrb), 32'd0);
        chk("lb_stall", 32'(stall_cyc), 32'd5);
        chk("lb_lat", 32'(lat), 32'd5);
        chk("lb_value", wb_data, 32'hFFFF_FF80);
        chk("lb_stall_after", 32'(stall), 32'd0);

        // LBU / LH / LHU / LW
        sb.push_back(mk(32'h0000_0080, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1));
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd8, 1'b1, 1, 32'h80FF_1122);
        sb.push_back(mk(32'hFFFF_8001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1));
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0106, 32'h0, 5'd9, 1'b1, 2, 32'h8001_7F02);
        sb.push_back(mk(32'h0000_8001, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1));
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0106, 32'h0, 5'd10, 1'b1, 1, 32'h8001_7F02);
        sb.push_back(mk(32'h0000_7F02, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1));
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0104, 32'h0, 5'd11, 1'b1, 1, 32'h8001_7F02);
        sb.push_back(mk(32'hCAFE_F00D, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1));
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'h0, 5'd12, 1'b1, 3, 32'hCAFE_F00D);
        chk("lw_lat", 32'(lat), 32'd4);

        // SH to the upper half
        sb.push_back(mk(32'hCAFE_F00D, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd3, 1'b1, 2, 32'h0);
        chk("sh_addr", req_addr, 32'h0000_0200);
        chk("sh_wstrb", 32'(req_wstrb), 32'hC);
        chk("sh_wdata", req_wdata, 32'hBEEF_BEEF);
        chk("sh_we", 32'(req_we), 32'd1);

        // SB to lane 1, SW
        sb.push_back(mk(32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 5'd3, 1'b0, 1, 32'h0);
        chk("sb_wstrb", 32'(req_wstrb), 32'h2);
        chk("sb_wdata", req_wdata, 32'hA5A5_A5A5);
        sb.push_back(mk(32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0304, 32'h0102_0304, 5'd3, 1'b0, 1, 32'h0);
        chk("sw_wstrb", 32'(req_wstrb), 32'hF);
        chk("sw_wdata", req_wdata, 32'h0102_0304);

        // Misaligned LW
        sb.push_back(mk(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0, 5'd4, 1'b1, 1, 32'h0);
        chk("mis_req", 32'(req_cyc), 32'd0);
        chk("mis_lat", 32'(lat), 32'd1);
        chk("mis_stall", 32'(stall_cyc), 32'd0);
        @(posedge clk); #1;
        chk("mis_pulse", 32'(exc_misaligned), 32'd0);
        chk("mis_wb_pulse", 32'(wb_valid), 32'd0);

        // Misaligned LH, illegal funct3
        sb.push_back(mk(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0303, 32'h0, 5'd4, 1'b1, 1, 32'h0);
        chk("mish_req", 32'(req_cyc), 32'd0);
        sb.push_back(mk(32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        issue(1'b0, 1'b1, 3'b011, 32'h0000_0300, 32'h0, 5'd4, 1'b1, 1, 32'h0);
        chk("illegal_req", 32'(req_cyc), 32'd0);

        // Timeout, then a late ack
        sb.push_back(mk(32'h0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0));
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd6, 1'b1, 0, 32'h0);
        chk("to_req_cycles", 32'(req_cyc), 32'd4);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_lat", 32'(lat), 32'd5);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        @(posedge clk); #1; dmem_ack = 1'b0;
        chk("late_ack_wb", 32'(wb_valid), 32'd0);
        chk("late_ack_berr", 32'(exc_bus_error), 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);

        // Reset during WAIT
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        ex_result = 32'h0000_0500; rd_in = 5'd2; reg_write_in = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("mid_req_up", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_wb", 32'(wb_valid), 32'd0);
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        @(posedge clk); #1; dmem_ack = 1'b0;
        chk("mid_rst_late_ack", 32'(wb_valid), 32'd0);
        chk("mid_rst_idle_req", 32'(dmem_req), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
